psram_arbiter: RTL and testbench

- Shares the single PSRAM memory controller between three requesters: port 0 = VIC-II video fetch, port 1 = 6510 CPU, port 2 = DMA/aux.
- Sequences the controller's handshake: active-low level chip-select, busy, and data-ready.
- Registers the selected address, bank, direction and write data toward the controller.
- Returns read data with a one-cycle acknowledge to the granted requester.

---
 rtl/psram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_psram_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_arbiter.sv
// Three-port arbiter (video, CPU, DMA) in front of a single PSRAM controller.
// Optional feature: define PSRAM_ARBITER_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module psram_arbiter #(
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned ISSUE_TIMEOUT = 16
) (
  input  logic                  i_clkRAM,
  input  logic                  reset,
  input  logic [2:0]            i_req,
  input  logic [2:0]            i_we,
  input  logic [3*ADDR_W-1:0]   i_addr,
  input  logic [2:0]            i_bank,
  input  logic [23:0]           i_wdata,
  output logic [2:0]            o_ack,
  output logic [7:0]            o_rdata,
  output logic [2:0]            o_grant,
  output logic                  o_timeout,
  output logic                  o_mem_cs,
  output logic                  o_mem_write,
  output logic [ADDR_W-1:0]     o_mem_address,
  output logic                  o_mem_bank,
  output logic [7:0]            o_mem_dataToWrite,
  input  logic                  i_mem_busy,
  input  logic                  i_mem_dataReady,
  input  logic [7:0]            i_mem_dataRead
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [7:0]          timer;
  logic                expired;
  logic                start;
  logic [2:0]          pick;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_bank;
  logic [7:0]          sel_wdata;

  assign expired = (timer == 8'(ISSUE_TIMEOUT - 1));
  assign start   = !i_mem_busy && (|i_req);

`ifdef PSRAM_ARBITER_ROUND_ROBIN_EN
  logic [1:0] ptr;

  // Search starts at ptr and wraps 2 -> 0; first requester found wins.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] idx;
    pick = '0;
    sum  = '0;
    idx  = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      sum = {1'b0, ptr} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if ((pick == 3'b000) && i_req[idx]) pick[idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clkRAM) begin
    if (reset) begin
      ptr <= '0;
    end else if (state == DONE) begin
      ptr <= o_grant[0] ? 2'd1 : (o_grant[1] ? 2'd2 : 2'd0);
    end
  end
`else
  always_comb begin
    pick = '0;
    if (i_req[0])      pick = 3'b001;
    else if (i_req[1]) pick = 3'b010;
    else if (i_req[2]) pick = 3'b100;
  end
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_bank  = 1'b0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (pick[k]) begin
        sel_we    = i_we[k];
        sel_addr  = i_addr[k*ADDR_W +: ADDR_W];
        sel_bank  = i_bank[k];
        sel_wdata = i_wdata[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clkRAM) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: begin
        if (i_mem_busy)   state_next = WAIT;
        else if (expired) state_next = IDLE;
      end
      WAIT:  if (!i_mem_busy) state_next = DONE;
      DONE:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clkRAM) begin
    if (reset) begin
      o_ack             <= '0;
      o_grant           <= '0;
      o_rdata           <= '0;
      o_timeout         <= 1'b0;
      o_mem_cs          <= 1'b1;
      o_mem_write       <= 1'b0;
      o_mem_address     <= '0;
      o_mem_bank        <= 1'b0;
      o_mem_dataToWrite <= '0;
      timer             <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            o_grant           <= pick;
            o_mem_write       <= sel_we;
            o_mem_address     <= sel_addr;
            o_mem_bank        <= sel_bank;
            o_mem_dataToWrite <= sel_wdata;
            o_mem_cs          <= 1'b0;
            timer             <= '0;
          end
        end
        ISSUE: begin
          if (i_mem_busy) begin
            o_mem_cs <= 1'b1;
          end else if (expired) begin
            // Abort leaves the request pending so IDLE re-arbitrates it.
            o_mem_cs  <= 1'b1;
            o_timeout <= 1'b1;
            o_grant   <= '0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        WAIT: begin
          if (!i_mem_busy) begin
            o_ack <= o_grant;
            if (!o_mem_write && i_mem_dataReady) o_rdata <= i_mem_dataRead;
          end
        end
        DONE: begin
          o_ack   <= '0;
          o_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a simple PSRAM controller model driven on the falling edge.
module tb_psram_arbiter;
  localparam int unsigned ADDR_W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset = 1'b1;
  logic [2:0]          req   = '0;
  logic [2:0]          we    = '0;
  logic [3*ADDR_W-1:0] addr  = '0;
  logic [2:0]          bank  = '0;
  logic [23:0]         wdata = '0;
  logic [2:0]          ack;
  logic [7:0]          rdata;
  logic [2:0]          grant;
  logic                timeout;
  logic                mem_cs;
  logic                mem_write;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_bank;
  logic [7:0]          mem_wdata;
  logic                busy  = 1'b1;
  logic                ready = 1'b0;
  logic [7:0]          dread = '0;

  int errors = 0;
  int checks = 0;

  // Controller model: mode 0 holds busy high, 1 responds to cs, 2 never responds.
  int         mode       = 0;
  int         busy_len   = 1;
  logic [7:0] model_data = '0;
  int         cnt        = 0;

  always @(negedge clk) begin
    ready = 1'b0;
    if (mode == 0) begin
      busy = 1'b1;
      cnt  = 0;
    end else if (busy) begin
      if (cnt <= 1) begin
        busy  = 1'b0;
        ready = 1'b1;
        dread = model_data;
      end else begin
        cnt = cnt - 1;
      end
    end else if (mode == 1 && mem_cs == 1'b0) begin
      busy = 1'b1;
      cnt  = busy_len;
    end
  end

  psram_arbiter #(.ADDR_W(ADDR_W), .ISSUE_TIMEOUT(16)) dut (
    .i_clkRAM          (clk),
    .reset             (reset),
    .i_req             (req),
    .i_we              (we),
    .i_addr            (addr),
    .i_bank            (bank),
    .i_wdata           (wdata),
    .o_ack             (ack),
    .o_rdata           (rdata),
    .o_grant           (grant),
    .o_timeout         (timeout),
    .o_mem_cs          (mem_cs),
    .o_mem_write       (mem_write),
    .o_mem_address     (mem_address),
    .o_mem_bank        (mem_bank),
    .o_mem_dataToWrite (mem_wdata),
    .i_mem_busy        (busy),
    .i_mem_dataReady   (ready),
    .i_mem_dataRead    (dread)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode  = 0;
    repeat (3) tick();
    checks++; if (mem_cs !== 1'b1)     begin errors++; $display("FAIL reset_cs: got %b want 1", mem_cs); end
    checks++; if (ack !== 3'b000)      begin errors++; $display("FAIL reset_ack: got %b want 000", ack); end
    checks++; if (grant !== 3'b000)    begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
    checks++; if (rdata !== 8'h00)     begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++; if ({mem_write, mem_bank, mem_address, mem_wdata} !== '0)
      begin errors++; $display("FAIL reset_mem_fields: got w=%b b=%b a=%h d=%h want all 0", mem_write, mem_bank, mem_address, mem_wdata); end
  endtask

  task automatic test_init_holdoff();
    bit ok = 1'b1;
    reset = 1'b0;
    we[1] = 1'b0;
    bank[1] = 1'b1;
    addr[1*ADDR_W +: ADDR_W] = 24'h012345;
    req = 3'b010;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (mem_cs !== 1'b1 || grant !== 3'b000) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL holdoff: cs/grant moved while busy (cs=%b grant=%b) want cs=1 grant=000", mem_cs, grant); end
    model_data = 8'hA5;
    busy_len   = 30;
    mode       = 1;
    tick();  // first cycle with busy low
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL holdoff_early: got grant %b want 000", grant); end
    tick();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL holdoff_grant: got %b want 010", grant); end
    checks++; if (mem_cs !== 1'b0)  begin errors++; $display("FAIL read_cs: got %b want 0", mem_cs); end
    checks++; if (mem_address !== 24'h012345 || mem_bank !== 1'b1 || mem_write !== 1'b0)
      begin errors++; $display("FAIL read_fields: got a=%h b=%b w=%b want a=012345 b=1 w=0", mem_address, mem_bank, mem_write); end
  endtask

  task automatic test_single_read();
    int n = 0;
    while (ack === 3'b000 && n < 100) begin
      tick();
      n++;
    end
    // Ack arrives busy_len+1 cycles after the grant cycle.
    checks++; if (n != busy_len + 1) begin errors++; $display("FAIL read_latency: got %0d want %0d", n, busy_len + 1); end
    checks++; if (ack !== 3'b010)    begin errors++; $display("FAIL read_ack: got %b want 010", ack); end
    checks++; if (rdata !== 8'hA5)   begin errors++; $display("FAIL read_data: got %h want a5", rdata); end
    req = 3'b000;
    tick();
    checks++; if (ack !== 3'b000 || grant !== 3'b000)
      begin errors++; $display("FAIL read_ack_pulse: got ack=%b grant=%b want 000/000", ack, grant); end
  endtask

  task automatic test_single_write();
    int lat = 1;
    busy_len   = 5;
    model_data = 8'h5A;
    we[2]      = 1'b1;
    bank[2]    = 1'b0;
    addr[2*ADDR_W +: ADDR_W] = 24'h000400;
    wdata[23:16] = 8'h3C;
    req = 3'b100;
    tick(); lat++;
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL write_grant: got %b want 100", grant); end
    checks++; if (mem_write !== 1'b1 || mem_wdata !== 8'h3C || mem_address !== 24'h000400 || mem_bank !== 1'b0)
      begin errors++; $display("FAIL write_fields: got w=%b d=%h a=%h b=%b want 1/3c/000400/0", mem_write, mem_wdata, mem_address, mem_bank); end
    wdata[23:16] = 8'hFF;
    addr[2*ADDR_W +: ADDR_W] = 24'hFFFFFF;
    tick(); lat++;
    checks++; if (mem_wdata !== 8'h3C || mem_address !== 24'h000400)
      begin errors++; $display("FAIL write_hold: got d=%h a=%h want 3c/000400", mem_wdata, mem_address); end
    while (ack === 3'b000 && lat < 100) begin
      tick(); lat++;
    end
    checks++; if (lat != 3 + busy_len) begin errors++; $display("FAIL write_latency: got %0d want %0d", lat, 3 + busy_len); end
    checks++; if (ack !== 3'b100)      begin errors++; $display("FAIL write_ack: got %b want 100", ack); end
    checks++; if (rdata !== 8'hA5)     begin errors++; $display("FAIL write_rdata_kept: got %h want a5", rdata); end
    req = 3'b000;
    we  = 3'b000;
    tick();
  endtask

  task automatic test_priority();
    logic [2:0] order [3];
    int k = 0;
    int n = 0;
    bit gap_check = 1'b0;
    busy_len = 3;
    order = '{default: 3'b000};
    req = 3'b111;
    while (k < 3 && n < 300) begin
      tick(); n++;
      if (gap_check) begin
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL prio_gap: got grant %b want 000", grant); end
        gap_check = 1'b0;
      end
      if (ack !== 3'b000) begin
        order[k] = ack;
        req = req & ~ack;
        gap_check = (k == 0);
        k++;
      end
    end
    checks++; if (k != 3) begin errors++; $display("FAIL prio_count: got %0d acks want 3", k); end
    checks++; if (order[0] !== 3'b001 || order[1] !== 3'b010 || order[2] !== 3'b100)
      begin errors++; $display("FAIL prio_order: got %b %b %b want 001 010 100", order[0], order[1], order[2]); end
    tick();
  endtask

  task automatic test_held_requests();
    logic [2:0] order [4];
    logic [2:0] want  [4];
    int k = 0;
    int n = 0;
`ifdef PSRAM_ARBITER_ROUND_ROBIN_EN
    want = '{3'b001, 3'b010, 3'b001, 3'b010};
`else
    want = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    order = '{default: 3'b000};
    model_data = 8'h77;
    req = 3'b011;
    while (k < 4 && n < 400) begin
      tick(); n++;
      if (ack !== 3'b000) begin
        order[k] = ack;
        k++;
      end
    end
    req = 3'b000;
    checks++; if (k != 4) begin errors++; $display("FAIL held_count: got %0d acks want 4", k); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (order[i] !== want[i]) begin errors++; $display("FAIL held_order[%0d]: got %b want %b", i, order[i], want[i]); end
    end
    tick();
  endtask

  task automatic test_timeout_reset();
    bit ok = 1'b1;
    bit acked = 1'b0;
    int late_acks = 0;
    mode = 2;
    req  = 3'b001;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (mem_cs !== 1'b0) ok = 1'b0;
      if (ack !== 3'b000) acked = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL timeout_cs_low: cs not held low for 16 cycles (now %b)", mem_cs); end
    tick();
    if (ack !== 3'b000) acked = 1'b1;
    checks++; if (mem_cs !== 1'b1 || timeout !== 1'b1 || grant !== 3'b000)
      begin errors++; $display("FAIL timeout_abort: got cs=%b to=%b grant=%b want 1/1/000", mem_cs, timeout, grant); end
    tick();
    if (ack !== 3'b000) acked = 1'b1;
    checks++; if (grant !== 3'b001 || mem_cs !== 1'b0)
      begin errors++; $display("FAIL timeout_regrant: got grant=%b cs=%b want 001/0", grant, mem_cs); end
    checks++; if (acked) begin errors++; $display("FAIL timeout_no_ack: got an ack want none"); end
    busy_len = 20;
    mode = 1;
    repeat (3) tick();
    checks++; if (mem_cs !== 1'b1 || grant !== 3'b001)
      begin errors++; $display("FAIL wait_state: got cs=%b grant=%b want 1/001", mem_cs, grant); end
    reset = 1'b1;
    req   = 3'b000;
    tick();
    checks++; if (mem_cs !== 1'b1 || ack !== 3'b000 || grant !== 3'b000)
      begin errors++; $display("FAIL midreset_ctrl: got cs=%b ack=%b grant=%b want 1/000/000", mem_cs, ack, grant); end
    checks++; if (timeout !== 1'b0 || rdata !== 8'h00)
      begin errors++; $display("FAIL midreset_flags: got to=%b rdata=%h want 0/00", timeout, rdata); end
    checks++; if ({mem_write, mem_bank, mem_address, mem_wdata} !== '0)
      begin errors++; $display("FAIL midreset_mem_fields: got w=%b b=%b a=%h d=%h want all 0", mem_write, mem_bank, mem_address, mem_wdata); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ack !== 3'b000) late_acks++;
    end
    checks++; if (late_acks != 0) begin errors++; $display("FAIL midreset_no_ack: got %0d acks want 0", late_acks); end
  endtask

  initial begin
    test_reset();
    test_init_holdoff();
    test_single_read();
    test_single_write();
    test_priority();
    test_held_requests();
    test_timeout_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
